hilo_ctrl: RTL and testbench
============================

Name: hilo_ctrl

Overview:
- Sequencer between the decode/execute stage and the multiply and divide engines.
- Accepts MULT/DIV/MTHI/MTLO requests, clears and starts the selected engine, and waits for its done level.
- Captures the engine result into the architectural HI/LO registers and raises busy so the pipeline stalls.
- Detects divide-by-zero and engine hang; reading hi_out/lo_out implements MFHI/MFLO.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before the operation is aborted.
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  request strobe; sampled only when busy=0.
- op_code  in  3  0 NOP, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO; 5-7 are treated as NOP.
- rs_val  in  32  first operand: multiplicand, dividend, or MTHI/MTLO data.
- rt_val  in  32  second operand: multiplier or divisor.
- busy  out  1  high while state != IDLE.
- hi_out  out  32  architectural HI register.
- lo_out  out  32  architectural LO register.
- op_done  out  1  one-cycle pulse when an operation completes successfully.
- div_zero  out  1  one-cycle pulse when a DIV with rt_val==0 is rejected.
- op_timeout  out  1  one-cycle pulse when an engine fails to finish in time.
- eng_clr  out  1  engine clear, driven to the selected engine's reset input.
- mult_start, div_start  out  1 each  one-cycle start pulses.
- eng_a, eng_b  out  32 each  registered operands, shared by both engines.
- mult_done, div_done  in  1 each  engine done levels; sticky until the engine is cleared.
- mult_hi, mult_lo, div_hi, div_lo  in  32 each  engine results.

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0, including hi_out, lo_out, eng_a, eng_b; wait counter 0.
- Reset during any state aborts the operation with no pulses; HI/LO become 0.
- IDLE, op_valid=1, MULT or DIV with divisor nonzero:
  - latch eng_a=rs_val, eng_b=rt_val, sel=op;
  - next state CLR.
- IDLE, DIV with rt_val==0: div_zero=1 next cycle; HI/LO unchanged; state stays IDLE; no engine activity.
- IDLE, MTHI or MTLO:
  - hi_out or lo_out = rs_val at the accepting edge;
  - op_done=1 the following cycle;
  - busy never rises.
- IDLE, NOP or op_valid=0: no action.
- CLR, one cycle: eng_clr=1. This clears the engine's stale sticky done. Next state START.
- START, one cycle: the selected start pulse is 1. Wait counter is zeroed. Next state WAIT.
- WAIT: counter increments every cycle.
  - Selected done=1: hi_out/lo_out take engine HI/LO at that edge; op_done=1 next cycle; state IDLE.
  - Counter reaches TIMEOUT_CYCLES with done still 0: op_timeout=1; HI/LO unchanged; state IDLE.
  - If done and timeout occur in the same cycle, done wins.
- Result mapping:
  - MULT: HI=upper product, LO=lower product; signed 64-bit Booth result as the engine delivers it.
  - DIV: HI=remainder, LO=quotient; the engine pins are wired accordingly.
- Latency, accept edge to op_done: 3 + engine latency cycles (CLR, START, WAIT entry). The radix-2 multiplier needs 33 WAIT cycles.
- Request handling while busy:
  - op_valid while busy=1 is ignored, not queued; the requester holds the request until busy=0.
  - A request presented on the cycle busy falls is accepted on that edge.
- eng_a and eng_b hold stable from accept until return to IDLE.
- All pulses (op_done, div_zero, op_timeout, start, eng_clr) are registered, glitch-free, and exactly one cycle wide.
- Only the selected engine is cleared and started; the unselected engine's inputs are untouched.

Decomposition:
- Shared package:
  - op_code constants (OP_NOP, OP_MULT, OP_DIV, OP_MTHI, OP_MTLO);
  - state encodings (IDLE, CLR, START, WAIT);
  - TIMEOUT_CYCLES default.
- The multiply and divide engines are instantiated by the parent, not inside this block.
- One natural sub-module: hilo_regs, holding the HI/LO register pair with write-enable and select, and the async reset to 0. The FSM, counter and pulse generation stay in hilo_ctrl.

Test Plan:
- MULT rs=7, rt=0xFFFFFFFD (-3) with the real multiplier attached -> busy for the engine duration; op_done once; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; eng_clr precedes mult_start by exactly 1 cycle.
- Two back-to-back MULTs (3*5, then 6*6) -> the second completes only after a fresh done (stale done cleared by eng_clr); lo_out=15 then 36; hi_out=0 both times.
- DIV rs=17, rt=5 with a stub divider (done after 10 cycles) -> lo_out=3, hi_out=2, op_done pulse. DIV rt=0 -> div_zero pulse one cycle after accept, busy stays 0, HI/LO unchanged.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi_out/lo_out update on each accepting edge; two op_done pulses; busy=0 throughout.
- Stub engine whose done never rises -> op_timeout pulse exactly TIMEOUT_CYCLES after WAIT entry; HI/LO keep prior values; a following MULT is accepted normally.
- Assert reset mid-WAIT of a MULT -> all outputs 0 immediately without a clock edge; no op_done after release; op_valid with busy=1 during a run is ignored (no second start pulse).

Source files
------------

// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: widths, op codes, FSM states.
package hilo_ctrl_pkg;

  localparam int unsigned DATA_W               = 32;
  localparam int unsigned OP_W                 = 3;
  localparam int unsigned HILO_TIMEOUT_DEFAULT = 64;

  localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd2;
  localparam logic [OP_W-1:0] OP_MTHI = 3'd3;
  localparam logic [OP_W-1:0] OP_MTLO = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_regs
  import hilo_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [DATA_W-1:0] hi_d, hi_q;
  logic [DATA_W-1:0] lo_d, lo_q;

  always_comb begin
    hi_d = we_hi ? hi_wdata : hi_q;
    lo_d = we_lo ? lo_wdata : lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer between decode/execute and the multiply/divide engines; owns HI/LO,
// stalls the pipe via busy and flags divide-by-zero and engine hangs.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = HILO_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op_code,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              op_done,
  output logic              div_zero,
  output logic              op_timeout,
  output logic              eng_clr,
  output logic              mult_start,
  output logic              div_start,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  input  logic              mult_done,
  input  logic              div_done,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_div_q, sel_div_d;
  logic [DATA_W-1:0] eng_a_q, eng_a_d;
  logic [DATA_W-1:0] eng_b_q, eng_b_d;
  logic              busy_q, busy_d;
  logic              op_done_q, op_done_d;
  logic              div_zero_q, div_zero_d;
  logic              op_timeout_q, op_timeout_d;
  logic              eng_clr_q, eng_clr_d;
  logic              mult_start_q, mult_start_d;
  logic              div_start_q, div_start_d;

  logic              we_hi, we_lo;
  logic [DATA_W-1:0] hi_wdata, lo_wdata;
  logic              accept_eng;
  logic              sel_done;
  logic              timeout_hit;

  // A DIV with a zero divisor is rejected in IDLE and never reaches an engine.
  assign accept_eng  = op_valid && ((op_code == OP_MULT) ||
                                    ((op_code == OP_DIV) && (rt_val != '0)));
  assign sel_done    = sel_div_q ? div_done : mult_done;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a done seen in the last WAIT cycle beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_eng) state_d = ST_CLR;
      ST_CLR:   state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (sel_done || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; pulses are decoded from the next state so they leave a flop
  always_comb begin
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    sel_div_d    = sel_div_q;
    cnt_d        = cnt_q;
    op_done_d    = 1'b0;
    div_zero_d   = 1'b0;
    op_timeout_d = 1'b0;
    we_hi        = 1'b0;
    we_lo        = 1'b0;
    hi_wdata     = rs_val;
    lo_wdata     = rs_val;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_MULT: begin
              eng_a_d   = rs_val;
              eng_b_d   = rt_val;
              sel_div_d = 1'b0;
            end
            OP_DIV: begin
              if (rt_val == '0) begin
                div_zero_d = 1'b1;
              end else begin
                eng_a_d   = rs_val;
                eng_b_d   = rt_val;
                sel_div_d = 1'b1;
              end
            end
            OP_MTHI: begin
              we_hi     = 1'b1;
              op_done_d = 1'b1;
            end
            OP_MTLO: begin
              we_lo     = 1'b1;
              op_done_d = 1'b1;
            end
            OP_NOP:  ;
            default: ;
          endcase
        end
      end
      ST_CLR:   ;
      ST_START: cnt_d = '0;
      ST_WAIT: begin
        if (sel_done) begin
          we_hi     = 1'b1;
          we_lo     = 1'b1;
          hi_wdata  = sel_div_q ? div_hi : mult_hi;
          lo_wdata  = sel_div_q ? div_lo : mult_lo;
          op_done_d = 1'b1;
        end else if (timeout_hit) begin
          op_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    busy_d       = (state_d != ST_IDLE);
    eng_clr_d    = (state_d == ST_CLR);
    mult_start_d = (state_d == ST_START) && !sel_div_d;
    div_start_d  = (state_d == ST_START) &&  sel_div_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      sel_div_q    <= 1'b0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      busy_q       <= 1'b0;
      op_done_q    <= 1'b0;
      div_zero_q   <= 1'b0;
      op_timeout_q <= 1'b0;
      eng_clr_q    <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sel_div_q    <= sel_div_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      busy_q       <= busy_d;
      op_done_q    <= op_done_d;
      div_zero_q   <= div_zero_d;
      op_timeout_q <= op_timeout_d;
      eng_clr_q    <= eng_clr_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
    end
  end

  hilo_regs u_regs (
    .clk      (clk),
    .reset    (reset),
    .we_hi    (we_hi),
    .we_lo    (we_lo),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  assign busy       = busy_q;
  assign op_done    = op_done_q;
  assign div_zero   = div_zero_q;
  assign op_timeout = op_timeout_q;
  assign eng_clr    = eng_clr_q;
  assign mult_start = mult_start_q;
  assign div_start  = div_start_q;
  assign eng_a      = eng_a_q;
  assign eng_b      = eng_b_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with behavioural multiply/divide engines.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_val, rt_val;
  logic        busy, op_done, div_zero, op_timeout, eng_clr, mult_start, div_start;
  logic [31:0] hi_out, lo_out, eng_a, eng_b;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;

  hilo_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi_out(hi_out), .lo_out(lo_out),
    .op_done(op_done), .div_zero(div_zero), .op_timeout(op_timeout), .eng_clr(eng_clr),
    .mult_start(mult_start), .div_start(div_start), .eng_a(eng_a), .eng_b(eng_b),
    .mult_done(mult_done), .div_done(div_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engines: done is sticky until eng_clr, rises LAT edges after start is sampled
  int  mult_lat = 33, div_lat = 10;
  bit  mult_hang = 1'b0;
  logic m_run, d_run;
  int  m_cnt, d_cnt;
  logic signed [63:0] prod;
  assign prod = $signed({{32{eng_a[31]}}, eng_a}) * $signed({{32{eng_b[31]}}, eng_b});

  always @(posedge clk) begin
    if (reset || eng_clr) begin
      mult_done <= 1'b0; m_run <= 1'b0; m_cnt <= 0;
      div_done  <= 1'b0; d_run <= 1'b0; d_cnt <= 0;
    end else begin
      if (mult_start) begin
        m_run <= 1'b1; m_cnt <= 1;
      end else if (m_run && !mult_hang) begin
        if (m_cnt == mult_lat) begin
          mult_done <= 1'b1; m_run <= 1'b0;
          mult_hi <= prod[63:32]; mult_lo <= prod[31:0];
        end else m_cnt <= m_cnt + 1;
      end
      if (div_start) begin
        d_run <= 1'b1; d_cnt <= 1;
      end else if (d_run) begin
        if (d_cnt == div_lat) begin
          div_done <= 1'b1; d_run <= 1'b0;
          div_hi <= eng_a % eng_b; div_lo <= eng_a / eng_b;
        end else d_cnt <= d_cnt + 1;
      end
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations collected over one issue window, cycle stamps relative to the accept edge
  int acc_c, n_done, n_dz, n_to, n_ms, n_ds, n_clr, done_c, dz_c, to_c, ms_c, clr_c;
  bit busy_seen;

  task automatic sample();
    if (op_done)    begin n_done++; done_c = cyc - acc_c; end
    if (div_zero)   begin n_dz++;   dz_c   = cyc - acc_c; end
    if (op_timeout) begin n_to++;   to_c   = cyc - acc_c; end
    if (mult_start) begin n_ms++;   ms_c   = cyc - acc_c; end
    if (div_start)  n_ds++;
    if (eng_clr)    begin n_clr++;  clr_c  = cyc - acc_c; end
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input int watch, input int poke_at);
    op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0;
    acc_c = cyc;
    n_done = 0; n_dz = 0; n_to = 0; n_ms = 0; n_ds = 0; n_clr = 0;
    done_c = -1; dz_c = -1; to_c = -1; ms_c = -1; clr_c = -1; busy_seen = 1'b0;
    sample();
    for (int i = 1; i < watch; i++) begin
      if (i == poke_at) begin
        op_valid = 1'b1; op_code = OP_MULT; rs_val = 32'h55; rt_val = 32'h66;
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
      sample();
    end
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = OP_NOP; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 64'({busy, op_done, div_zero, op_timeout, eng_clr, mult_start, div_start}), 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_eng", {eng_a, eng_b}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 7 * -3
    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 40, -1);
    check("mul1_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mul1_ndone", 64'(n_done), 64'd1);
    check("mul1_lat", 64'(done_c), 64'd36);
    check("mul1_clr_at", 64'(clr_c), 64'd0);
    check("mul1_clr2start", 64'(ms_c - clr_c), 64'd1);
    check("mul1_starts", 64'({n_ms, n_ds}), {32'd1, 32'd0});
    check("mul1_busy", 64'(busy_seen), 64'd1);

    // Back-to-back: second run must wait for a fresh done
    issue(OP_MULT, 32'd3, 32'd5, 37, -1);
    check("mul2_hilo", {hi_out, lo_out}, 64'd15);
    check("mul2_lat", 64'(done_c), 64'd36);
    issue(OP_MULT, 32'd6, 32'd6, 40, -1);
    check("mul3_hilo", {hi_out, lo_out}, 64'd36);
    check("mul3_lat", 64'(done_c), 64'd36);
    check("mul3_ndone", 64'(n_done), 64'd1);

    issue(OP_DIV, 32'd17, 32'd5, 20, -1);
    check("div_hilo", {hi_out, lo_out}, {32'd2, 32'd3});
    check("div_lat", 64'(done_c), 64'd13);
    check("div_starts", 64'({n_ms, n_ds}), {32'd0, 32'd1});

    issue(OP_DIV, 32'd99, 32'd0, 5, -1);
    check("dz_n", 64'(n_dz), 64'd1);
    check("dz_at", 64'(dz_c), 64'd0);
    check("dz_quiet", 64'({busy_seen, n_done[0], n_clr[0], n_ds[0], n_ms[0]}), 64'd0);
    check("dz_hilo", {hi_out, lo_out}, {32'd2, 32'd3});

    // MTHI then MTLO on consecutive cycles
    op_valid = 1'b1; op_code = OP_MTHI; rs_val = 32'hDEAD_BEEF; rt_val = '0;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi_out), 64'hDEAD_BEEF);
    check("mthi_done_busy", 64'({op_done, busy}), 64'b10);
    op_code = OP_MTLO; rs_val = 32'h1234_5678;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("mtlo_hilo", {hi_out, lo_out}, 64'hDEAD_BEEF_1234_5678);
    check("mtlo_done_busy", 64'({op_done, busy}), 64'b10);
    @(posedge clk); #1;
    check("mt_done_drop", 64'(op_done), 64'd0);

    // Hung multiplier
    mult_hang = 1'b1;
    issue(OP_MULT, 32'd2, 32'd2, 80, -1);
    check("to_n", 64'(n_to), 64'd1);
    check("to_at", 64'(to_c), 64'd66);
    check("to_ndone", 64'(n_done), 64'd0);
    check("to_hilo", {hi_out, lo_out}, 64'hDEAD_BEEF_1234_5678);
    check("to_idle", 64'(busy), 64'd0);
    mult_hang = 1'b0;

    // Recovery MULT with a stray request mid-run that must be ignored
    issue(OP_MULT, 32'd6, 32'd7, 40, 10);
    check("rec_hilo", {hi_out, lo_out}, 64'd42);
    check("rec_lat", 64'(done_c), 64'd36);
    check("ign_starts", 64'(n_ms), 64'd1);
    check("ign_eng", {eng_a, eng_b}, {32'd6, 32'd7});

    // Reset mid-WAIT, no clock edge needed
    issue(OP_MULT, 32'd9, 32'd9, 10, -1);
    check("mid_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_ctl", 64'({busy, op_done, div_zero, op_timeout, eng_clr, mult_start, div_start}), 64'd0);
    check("arst_hilo", {hi_out, lo_out}, 64'd0);
    check("arst_eng", {eng_a, eng_b}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    n_done = 0; busy_seen = 1'b0; acc_c = cyc;
    repeat (50) begin
      @(posedge clk); #1;
      sample();
    end
    check("post_rst_quiet", 64'({n_done[0], busy_seen}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
